// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage. Owns the program counter, issues one instruction
// memory request at a time over a valid/ready handshake and hands
// {pc, pc+PC_STEP, instruction} to decode over a second valid/ready
// handshake. Branch/jump redirects from later stages retarget the PC. A
// response already in flight when a redirect lands is discarded.
//
// Parameters
//   ADDR_W    PC / memory address width
//   INSN_W    instruction word width
//   PC_STEP   sequential PC increment (power of two, >= 1)
//   RESET_PC  PC loaded on reset
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   redirect_valid    redirect request from execute/branch logic
//   redirect_pc       redirect target (low log2(PC_STEP) bits ignored)
//   imem_req_valid    fetch request valid
//   imem_req_addr     fetch address
//   imem_req_ready    memory accepts the request
//   imem_rsp_valid    fetch response valid (one per accepted request)
//   imem_rsp_data     fetched instruction
//   if_valid          instruction valid to decode
//   if_ready          decode accepts the instruction
//   if_pc             address of the presented instruction
//   if_pc_next        if_pc + PC_STEP (wraps modulo 2^ADDR_W)
//   if_insn           presented instruction
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSN_W   = 32,
    parameter int unsigned        PC_STEP  = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,

    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,

    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_next,
    output logic [INSN_W-1:0] if_insn
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    // Clears the sub-instruction offset bits of a redirect target.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    // Set when the outstanding request belongs to a path abandoned by a
    // redirect; its response must be thrown away.
    logic                r_drop;
    logic                w_drop_nxt;

    logic [ADDR_W-1:0]   r_if_pc;
    logic [ADDR_W-1:0]   r_if_pc_next;
    logic [INSN_W-1:0]   r_if_insn;
    logic                w_capture;

    logic [ADDR_W-1:0]   w_redir_tgt;
    logic [ADDR_W-1:0]   w_pc_inc;

    assign w_redir_tgt = redirect_pc & ALIGN_MASK;
    assign w_pc_inc    = r_pc + STEP;

    // -------------------------------------------------------------------------
    // State register (plus PC, drop flag and the decode-facing holding regs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_if_pc      <= '0;
            r_if_pc_next <= '0;
            r_if_insn    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_capture) begin
                r_if_pc      <= r_pc;
                r_if_pc_next <= w_pc_inc;
                r_if_insn    <= imem_rsp_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_capture   = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Redirects are not honoured here.
                w_state_nxt = REQ;
            end

            REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_tgt;
                    // Request accepted this cycle targets the old path.
                    if (imem_req_ready) begin
                        w_drop_nxt = 1'b1;
                    end
                end
                if (imem_req_ready) begin
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        // Response consumed and discarded; nothing left in
                        // flight, so the drop flag is cleared, not set.
                        w_pc_nxt    = w_redir_tgt;
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    w_pc_nxt   = w_redir_tgt;
                    w_drop_nxt = 1'b1;
                end
            end

            HOLD: begin
                // A redirect masks if_valid, so a coincident if_ready is
                // not a transfer.
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_tgt;
                    w_state_nxt = REQ;
                end else if (if_ready) begin
                    w_state_nxt = REQ;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req_valid = (r_state == REQ);
        imem_req_addr  = r_pc;
        if_valid       = (r_state == HOLD) && !redirect_valid;
        if_pc          = r_if_pc;
        if_pc_next     = r_if_pc_next;
        if_insn        = r_if_insn;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Bench for pc_fetch_unit. A behavioural memory answers each accepted request
// after a chosen latency with a word derived from the address. The reference
// model is the architectural instruction stream: after reset decode must see
// RESET_PC, after every transfer the next sequential address, and after every
// honoured redirect the aligned target. Expected entries are queued when
// stimulus is issued; a monitor compares whenever if_valid is presented.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam int unsigned AW  = 32;
    localparam int unsigned IW  = 32;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          if_valid;
    logic          if_ready;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc_next;
    logic [IW-1:0] if_insn;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .ADDR_W   (AW),
        .INSN_W   (IW),
        .PC_STEP  (4),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_pc_next     (if_pc_next),
        .if_insn        (if_insn)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    bit          ideal   = 1'b0;
    int          mem_lat = 1;
    bit          mem_pending = 1'b0;
    bit          prev_rst;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    bit          m_acc;
    bit          m_rst;
    logic [31:0] m_req_addr;
    logic [31:0] m_addr;
    int          m_cnt;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            m_acc      = imem_req_valid && imem_req_ready;
            m_req_addr = imem_req_addr;
            m_rst      = rst;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (m_rst) begin
                mem_pending = 1'b0;
            end else begin
                if (m_acc) begin
                    mem_pending = 1'b1;
                    m_addr      = m_req_addr;
                    m_cnt       = ((mem_lat != 0) ? mem_lat : int'($urandom_range(1, 5))) - 1;
                end else if (mem_pending) begin
                    m_cnt--;
                end
                if (mem_pending && m_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = insn_of(m_addr);
                    mem_pending    = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          rcnt = 0;
    int          lastx = 0;
    bit          lastx_valid = 1'b0;
    int          wd = 0;
    logic [31:0] e;
    logic [31:0] en;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rcnt        = 0;
                lastx_valid = 1'b0;
                wd          = 0;
            end else begin
                rcnt++;
                wd++;
                if (rcnt == 1) begin
                    chk("rst_req_valid", imem_req_valid, 0);
                    chk("rst_if_valid", if_valid, 0);
                    chk("rst_if_pc", if_pc, 0);
                    chk("rst_if_pc_next", if_pc_next, 0);
                    chk("rst_if_insn", if_insn, 0);
                end
                if (rcnt == 2) begin
                    chk("first_req_valid", imem_req_valid, 1);
                    chk("first_req_addr", imem_req_addr, RPC);
                end
                if (imem_req_valid) begin
                    chk("one_outstanding", {mem_pending, if_valid}, 0);
                end
                if (if_valid) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL if_valid_unexpected: got if_pc 0x%0h, no instruction expected", if_pc);
                    end else begin
                        e  = exp_q[0];
                        en = e + 32'd4;
                        chk("if_pc", if_pc, e);
                        chk("if_pc_next", if_pc_next, en);
                        chk("if_insn", if_insn, insn_of(e));
                        if (if_ready) begin
                            void'(exp_q.pop_front());
                            exp_q.push_back(en);
                            wd = 0;
                            if (ideal) begin
                                chk("xfer_cycle", rcnt, lastx_valid ? lastx + 3 : 4);
                            end
                            lastx       = rcnt;
                            lastx_valid = 1'b1;
                        end
                    end
                end
                if (wd > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL watchdog: got %0d cycles without transfer, required <= 200", wd);
                    wd = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit r, input bit rv, input logic [31:0] rp,
                         input bit ifr, input bit mr);
        logic [31:0] tgt;
        rst            = r;
        redirect_valid = rv && !r;
        redirect_pc    = rp;
        if_ready       = ifr && !r;
        imem_req_ready = mr;
        if (r) begin
            exp_q.delete();
            exp_q.push_back(RPC);
        end else if (rv && !prev_rst) begin
            // Redirects in the cycle right after reset release are ignored.
            tgt = rp & 32'hFFFF_FFFC;
            exp_q.delete();
            exp_q.push_back(tgt);
        end
        prev_rst = r;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            apply(1, 0, 32'h0, 0, 1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            apply(0, 0, 32'h0, 1, 1);
        end
    endtask

    // Returns in the first WAIT cycle after an accepted request; the caller
    // drives that cycle's inputs.
    task automatic wait_accept();
        bit seen;
        bit found;
        seen  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (seen) begin
                found = 1'b1;
                break;
            end
            seen = imem_req_valid;
            apply(0, 0, 32'h0, 1, 1);
        end
        chk("wait_accept_found", found, 1);
    endtask

    task automatic wait_if_valid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (if_valid) begin
                found = 1'b1;
                break;
            end
            apply(0, 0, 32'h0, 1, 1);
        end
        chk("wait_if_valid_found", found, 1);
    endtask

    task automatic expect_next_req(input string name, input logic [31:0] addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (imem_req_valid) begin
                chk(name, imem_req_addr, addr);
                found = 1'b1;
                apply(0, 0, 32'h0, 1, 1);
                break;
            end
            apply(0, 0, 32'h0, 1, 1);
        end
        if (!found) begin
            chk({name, "_seen"}, found, 1);
        end
    endtask

    logic [31:0] rnd;
    logic [31:0] tgt_r;
    bit          r_r;
    bit          rv_r;

    initial begin
        rst            = 1'b1;
        prev_rst       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        exp_q.push_back(RPC);

        // In-order sequential fetch, ideal memory and decode.
        ideal   = 1'b1;
        mem_lat = 1;
        do_reset(3);
        run(24);
        ideal = 1'b0;

        // Decode backpressure for 5 cycles while holding an instruction.
        for (int k = 0; k < 2; k++) begin
            wait_if_valid();
            apply(0, 0, 32'h0, 0, 1);
            for (int i = 0; i < 4; i++) begin
                tick();
                apply(0, 0, 32'h0, 0, 1);
            end
            run(6);
        end

        // Redirect while waiting on a 4-cycle memory.
        mem_lat = 4;
        wait_accept();
        apply(0, 1, 32'h0000_1003, 1, 1);
        expect_next_req("redir_wait_req_addr", 32'h0000_1000);
        run(20);

        // Redirect coincident with the response.
        mem_lat = 1;
        wait_accept();
        apply(0, 1, 32'h0000_2006, 1, 1);
        expect_next_req("redir_rsp_req_addr", 32'h0000_2004);
        run(8);

        // Redirect coincident with if_ready in HOLD.
        wait_if_valid();
        apply(0, 1, 32'h0000_3ABF, 1, 1);
        #1;
        chk("hold_redir_if_valid", if_valid, 0);
        expect_next_req("redir_hold_req_addr", 32'h0000_3ABC);
        run(8);

        // PC wrap at the top of the address space.
        tick();
        apply(0, 1, 32'hFFFF_FFFE, 1, 1);
        expect_next_req("wrap_req_top", 32'hFFFF_FFFC);
        expect_next_req("wrap_req_zero", 32'h0000_0000);
        run(10);

        // Reset in the middle of a memory wait.
        mem_lat = 4;
        wait_accept();
        apply(1, 0, 32'h0, 0, 1);
        run(30);

        // Randomised traffic.
        mem_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            r_r  = ($urandom_range(0, 199) == 0);
            rv_r = ($urandom_range(0, 11) == 0);
            rnd  = $urandom;
            case ($urandom_range(0, 3))
                0:       tgt_r = rnd;
                1:       tgt_r = 32'hFFFF_FFF0 | {28'h0, rnd[3:0]};
                2:       tgt_r = 32'h0000_1003;
                default: tgt_r = RPC + {26'h0, rnd[5:0]};
            endcase
            apply(r_r, rv_r, tgt_r, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7));
        end
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised instruction-fetch stage that owns the program counter and issues one fetch request at a time to instruction memory over a valid/ready handshake. It returns {pc, pc+step, instruction} to decode over a second valid/ready handshake. It supports branch/jump redirect and discards stale in-flight responses after a redirect. It sits between the PC-redirect logic of later stages and the decode stage.

Parameters:
ADDR_W, 32, PC and memory address width in bits
INSN_W, 32, instruction word width in bits
PC_STEP, 4, sequential PC increment; power of two, >= 1
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
redirect_valid  input  1  redirect request from execute/branch logic
redirect_pc  input  ADDR_W  redirect target address
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  ADDR_W  fetch address
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  fetch response valid; one response per accepted request, any latency >= 1
imem_rsp_data  input  INSN_W  fetched instruction
if_valid  output  1  fetched instruction valid to decode
if_ready  input  1  decode accepts instruction
if_pc  output  ADDR_W  address of presented instruction
if_pc_next  output  ADDR_W  if_pc + PC_STEP, modulo 2^ADDR_W
if_insn  output  INSN_W  presented instruction

Behaviour:
- State machine states: IDLE, REQ, WAIT, HOLD. Internal registers: pc, drop flag.
- Reset (rst=1 at clock edge):
  - state <= IDLE, pc <= RESET_PC, drop <= 0.
  - if_pc, if_pc_next, if_insn <= 0.
  - Resulting outputs: imem_req_valid=0, if_valid=0.
  - rst overrides every other input, including mid-request. Responses arriving after reset for pre-reset requests are a system error; the memory must be reset together with this block.
- IDLE: one cycle, then -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc.
  - ready=1, no redirect: -> WAIT.
  - redirect, ready=0: pc <= redirect target, stay REQ. Address changes next cycle; the memory tolerates this.
  - redirect, ready=1: pc <= redirect target, drop <= 1, -> WAIT.
- WAIT: imem_req_valid=0.
  - rsp_valid, drop=0, no redirect: if_insn <= rsp_data, if_pc <= pc, if_pc_next <= pc+PC_STEP, pc <= pc+PC_STEP, -> HOLD.
  - rsp_valid, drop=1: discard response, drop <= 0, -> REQ.
  - redirect, no rsp_valid: pc <= target, drop <= 1, stay WAIT.
  - redirect and rsp_valid together: discard response, pc <= target, drop <= 0, -> REQ.
- HOLD: if_valid = 1 AND NOT redirect_valid (combinational).
  - if_valid & if_ready: -> REQ.
  - redirect: pc <= target, -> REQ. The presented instruction is never transferred; a same-cycle if_ready is void.
  - Otherwise hold; if_* outputs stable while if_valid=1 and if_ready=0.
- Redirect target = redirect_pc with its low log2(PC_STEP) bits forced to 0.
- PC arithmetic is unsigned modulo 2^ADDR_W. The all-ones-aligned PC wraps to 0; no flag.
- Redirect is honoured only in REQ, WAIT and HOLD. In IDLE it is ignored; the reset path never needs it.
- Latency: first imem_req_valid occurs 2 cycles after rst deasserts. With always-ready memory, 1-cycle response and always-ready decode, throughput is 1 instruction per 3 cycles.
- At most one outstanding memory request at any time.

Test Plan:
- Reset sequencing, RESET_PC=0x00400000, ideal memory (1-cycle latency, ready=1), if_ready=1: instructions at 0x00400000, 0x00400004, 0x00400008 appear in order; if_pc_next = if_pc+4; one every 3 cycles.
- Backpressure, if_ready=0 for 5 cycles in HOLD: if_valid stays 1, if_pc/if_insn unchanged, no new imem request; resumes fetch of pc+4 after accept.
- Redirect in WAIT to 0x00001003 with 4-cycle memory latency: the stale response is dropped, the next request address is 0x00001000, and decode never sees the stale instruction.
- Redirect coincident with rsp_valid in WAIT, and coincident with if_ready in HOLD: response/transfer voided, next request goes to the target, if_valid=0 that cycle.
- Wrap and mid-operation reset, ADDR_W=32, pc=0xFFFFFFFC: next fetch is 0x00000000. Then assert rst during WAIT: next cycle imem_req_valid=0, if_valid=0, pc=RESET_PC; fetch restarts 2 cycles after release.
